seg_scan_ctrl: RTL and testbench

- Time-multiplexes one 4-bit-to-7-segment decoder across NUM_DIGITS common-anode digits of the score display in the 2-player catch game.
- Game logic hands over new digit values through a load/ack handshake.
- The block commits them tear-free at a scan-frame boundary, then cycles the anodes at a fixed refresh rate.
- Applies a per-slot ghosting guard and a per-digit blank mask.

---
 rtl/seg_scan_pkg.sv | 16 +
 rtl/seg_scan_ctrl_if.sv | 15 +
 rtl/seg_scan_ctrl_hex7_dec.sv | 11 +
 rtl/seg_scan_ctrl.sv | 127 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and the 4-bit to 7-segment lookup for the score display scanner.
// Segment codes are active-low, ordered {a,b,c,d,e,f,g} from bit 6 down to bit 0.
package seg_scan_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_TABLE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/ack handshake between the game logic (master) and the display scanner (slave).
interface seg_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);

  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   blank_in;
  logic                    load_ack;
  logic                    busy;

  modport master (output load, digits_in, blank_in, input load_ack, busy);
  modport slave  (input load, digits_in, blank_in, output load_ack, busy);

endinterface

// File: rtl/seg_scan_ctrl_hex7_dec.sv
// Pure combinational hex nibble to active-low 7-segment decoder.
module hex7_dec
  import seg_scan_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scanner with tear-free frame-boundary commit of new digits.
// Optional leading-zero suppression is enabled by defining SEG_SCAN_LZ_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_ctrl_if.slave        bus,
  output seg_t                  seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]           div_cnt_q;
  logic [IW-1:0]           idx_q;
  logic                    slot_end;
  logic                    frame_end;

  logic [4*NUM_DIGITS-1:0] pend_digits_q;
  logic [NUM_DIGITS-1:0]   pend_blank_q;
  logic [4*NUM_DIGITS-1:0] shadow_digits_q;
  logic [NUM_DIGITS-1:0]   shadow_blank_q;
  logic                    busy_q;
  logic                    ack_q;

  logic [NUM_DIGITS-1:0]   lz_mask;
  logic [NUM_DIGITS-1:0]   blank_eff;
  logic [3:0]              cur_nibble;
  seg_t                    dec_seg;
  seg_t                    seg_d, seg_q;
  logic [NUM_DIGITS-1:0]   an_d, an_q;

  assign slot_end  = (div_cnt_q == CW'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx_q == IW'(NUM_DIGITS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= '0;
    end else if (slot_end) begin
      div_cnt_q <= '0;
      idx_q     <= (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_cnt_q <= div_cnt_q + 1'b1;
    end
  end

  // A load landing on the frame boundary bypasses the pending buffer so it is shown next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_digits_q   <= '0;
      pend_blank_q    <= '0;
      shadow_digits_q <= '0;
      shadow_blank_q  <= '1;
      busy_q          <= 1'b0;
      ack_q           <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (frame_end && (bus.load || busy_q)) begin
        shadow_digits_q <= bus.load ? bus.digits_in : pend_digits_q;
        shadow_blank_q  <= bus.load ? bus.blank_in  : pend_blank_q;
        busy_q          <= 1'b0;
        ack_q           <= 1'b1;
      end else if (bus.load) begin
        busy_q <= 1'b1;
      end
      if (bus.load) begin
        pend_digits_q <= bus.digits_in;
        pend_blank_q  <= bus.blank_in;
      end
    end
  end

`ifdef SEG_SCAN_LZ_BLANK_EN
  // Walk down from the top digit; a digit is suppressed while it and everything above it is zero.
  always_comb begin
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run && (shadow_digits_q[4*k +: 4] == 4'd0);
      lz_mask[k] = zero_run;
    end
  end
`else
  assign lz_mask = '0;
`endif

  assign blank_eff  = shadow_blank_q | lz_mask;
  assign cur_nibble = shadow_digits_q[{idx_q, 2'b00} +: 4];

  hex7_dec u_dec (
    .nibble_i (cur_nibble),
    .seg_o    (dec_seg)
  );

  // Anodes stay off during the guard window so the previous digit's pattern cannot ghost.
  always_comb begin
    seg_d = blank_eff[idx_q] ? SEG_BLANK : dec_seg;
    an_d  = '1;
    if (div_cnt_q >= CW'(GUARD)) begin
      an_d = ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg          = seg_q;
  assign an           = an_q;
  assign bus.load_ack = ack_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: stimulus queues the expected frame per commit, a monitor checks it after each ack.
module tb_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 8;
  localparam int GD    = 2;
  localparam int FRAME = ND * RD;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b1001111;
  localparam logic [6:0] S2 = 7'b0010010;
  localparam logic [6:0] S3 = 7'b0000110;
  localparam logic [6:0] S4 = 7'b1001100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b1100000;
  localparam logic [6:0] SC = 7'b0110001;
  localparam logic [6:0] SD = 7'b1000010;
  localparam logic [6:0] SX = 7'b1111111;
`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam logic [6:0] SZ = SX;
`else
  localparam logic [6:0] SZ = S0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    seg;
  logic [ND-1:0] an;

  int            checks = 0;
  int            errors = 0;
  int            tcount;
  bit            monBusy = 1'b0;
  logic [27:0]   expQ [$];

  seg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .REFRESH_DIV (RD),
    .GUARD       (GD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Scan position model: number of counting edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tcount <= 0;
    else        tcount <= tcount + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                        input logic [6:0] d1, input logic [6:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic waitPhase(input int p);
    int n = 0;
    @(negedge clk);
    while ((tcount % FRAME) != p && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    checkOutput($sformatf("phase_reached_%0d", p), tcount % FRAME, p);
  endtask

  task automatic applyStimulus(input logic [15:0] digits, input logic [3:0] blank, input int p);
    waitPhase(p);
    bus.load      = 1'b1;
    bus.digits_in = digits;
    bus.blank_in  = blank;
    @(negedge clk);
    bus.load      = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while ((expQ.size() != 0 || monBusy) && n < 400);
    checkOutput("idle_reached", (expQ.size() == 0 && !monBusy), 1);
  endtask

  // After each ack, the following frame must show the queued digits with guard gaps.
  initial begin : monitor
    logic [27:0]   e;
    logic [ND-1:0] expAn;
    int            slot;
    int            pos;
    forever begin
      @(negedge clk);
      if (rst_n && bus.load_ack) begin
        checkOutput("ack_was_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e       = expQ.pop_front();
          monBusy = 1'b1;
          for (int t = 1; t <= FRAME; t++) begin
            @(negedge clk);
            slot  = (t - 1) / RD;
            pos   = (t - 1) % RD;
            expAn = (pos < GD) ? 4'b1111 : ~(4'b0001 << slot);
            checkOutput($sformatf("an_s%0d_p%0d", slot, pos), an, expAn);
            checkOutput($sformatf("seg_s%0d_p%0d", slot, pos), seg, e[slot*7 +: 7]);
            checkOutput($sformatf("ack_single_s%0d_p%0d", slot, pos), bus.load_ack, 0);
          end
          monBusy = 1'b0;
        end
      end
    end
  end

  initial begin
    bus.load      = 1'b0;
    bus.digits_in = '0;
    bus.blank_in  = '0;
    rst_n         = 1'b0;

    repeat (5) @(negedge clk);
    checkOutput("reset_an", an, 4'hF);
    checkOutput("reset_seg", seg, SX);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_ack", bus.load_ack, 0);
    rst_n = 1'b1;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      checkOutput("dark_seg", seg, SX);
      checkOutput("dark_busy", bus.busy, 0);
    end

    expQ.push_back(pack4(S1, S2, S3, S4));
    applyStimulus(16'h1234, 4'b0000, 10);
    checkOutput("commit_busy_set", bus.busy, 1);
    waitPhase(31);
    checkOutput("commit_busy_held", bus.busy, 1);
    @(negedge clk);
    checkOutput("commit_busy_clear", bus.busy, 0);
    checkOutput("commit_ack", bus.load_ack, 1);
    waitIdle();

    expQ.push_back(pack4(SA, SB, SC, SD));
    applyStimulus(16'h1111, 4'b0000, 5);
    applyStimulus(16'hABCD, 4'b0000, 10);
    checkOutput("overwrite_busy", bus.busy, 1);
    waitIdle();

    expQ.push_back(pack4(SZ, SZ, SZ, S9));
    applyStimulus(16'h0009, 4'b0000, 31);
    checkOutput("coincident_busy", bus.busy, 0);
    checkOutput("coincident_ack", bus.load_ack, 1);
    waitIdle();

    expQ.push_back(pack4(SX, S6, S7, S8));
    applyStimulus(16'h5678, 4'b1000, 3);
    waitIdle();

    expQ.push_back(pack4(SZ, SZ, S7, S0));
    applyStimulus(16'h0070, 4'b0000, 20);
    waitIdle();

    applyStimulus(16'h4321, 4'b0000, 10);
    checkOutput("abort_busy_set", bus.busy, 1);
    waitPhase(13);
    checkOutput("abort_an_active", an, 4'b1101);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_an_dark", an, 4'hF);
    checkOutput("abort_seg_dark", seg, SX);
    checkOutput("abort_busy_clear", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      checkOutput("abort_busy_stays_clear", bus.busy, 0);
    end
    checkOutput("abort_no_pending_expect", expQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
